// File: rtl/outr_tx_pkg.sv
// Shared types and constants for the OUTR serial transmitter.
// Holds the FSM state encoding, the default bit period and a frame length helper.
package outr_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 16;

   function automatic int frame_len(input int u, input int clks, input bit parity_en);
      return (u + 2 + (parity_en ? 1 : 0)) * clks;
   endfunction

endpackage

// File: rtl/outr_serial_tx_baud.sv
// Baud tick generator: free-running 0..CLKS_PER_BIT-1 counter with a synchronous restart.
// tick is high during the last cycle of each bit period.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic restart,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (restart || (cnt == LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/outr_serial_tx.sv
// Serial transmitter behind OUTR: accepts a byte on LD while FGO=1 and shifts it out LSB first.
// Define TX_PARITY_EN to append an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, FGO=1, waiting for LD
// START  | start bit (TXD=0)
// DATA   | u data bits, LSB first
// PARITY | even-parity bit (TX_PARITY_EN builds only)
// STOP   | stop bit (TXD=1); FGO returns at its last tick
module outr_serial_tx
   import outr_tx_pkg::*;
#(
   parameter int u            = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [u-1:0] Data_in,
   input  logic         LD,
   input  logic         IEN,
   output logic         FGO,
   output logic         BUSY,
   output logic         TXD,
   output logic         IRQ
);

   localparam int BW = $clog2(u) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(u - 1);

   tx_state_t     state_q, state_d;
   logic [u-1:0]  shreg_q, shreg_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          txd_q, txd_d;
   logic          fgo_q, fgo_d;
   logic          busy_q, busy_d;
   logic          irq_q;
   logic          restart;
   logic          tick;
`ifdef TX_PARITY_EN
   logic          parity_q, parity_d;
`endif

   baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         txd_q     <= 1'b1;
         fgo_q     <= 1'b1;
         busy_q    <= 1'b0;
         irq_q     <= 1'b0;
`ifdef TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         txd_q     <= txd_d;
         fgo_q     <= fgo_d;
         busy_q    <= busy_d;
         irq_q     <= fgo_q & IEN;
`ifdef TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      txd_d     = txd_q;
      fgo_d     = fgo_q;
      busy_d    = busy_q;
      restart   = 1'b0;
`ifdef TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            // Only a registered FGO=1 admits a byte, so LD on the last STOP tick is dropped.
            if (LD && fgo_q) begin
               shreg_d = Data_in;
               fgo_d   = 1'b0;
               busy_d  = 1'b1;
               txd_d   = 1'b0;
               restart = 1'b1;
               state_d = START;
`ifdef TX_PARITY_EN
               parity_d = ^Data_in;
`endif
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               txd_d     = shreg_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
                  state_d = PARITY;
                  txd_d   = parity_q;
`else
                  state_d = STOP;
                  txd_d   = 1'b1;
`endif
               end else begin
                  shreg_d   = shreg_q >> 1;
                  txd_d     = shreg_q[1];
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               txd_d   = 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               fgo_d   = 1'b1;
               busy_d  = 1'b0;
               txd_d   = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   assign FGO  = fgo_q;
   assign BUSY = busy_q;
   assign TXD  = txd_q;
   assign IRQ  = irq_q;

endmodule

// File: tb/tb_outr_serial_tx.sv
// Directed self-checking bench for outr_serial_tx (u=8, CLKS_PER_BIT=16).
// Works in both builds; define TX_PARITY_EN to exercise the parity frame.
module tb_outr_serial_tx;

`ifdef TX_PARITY_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif
   localparam int CPB = 16;
   localparam int FL  = PE ? 176 : 160;

   logic       CLK;
   logic       RST_N;
   logic [7:0] Data_in;
   logic       LD;
   logic       IEN;
   logic       FGO;
   logic       BUSY;
   logic       TXD;
   logic       IRQ;

   int checks = 0;
   int errors = 0;

   outr_serial_tx #(.u(8), .CLKS_PER_BIT(CPB)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .Data_in (Data_in),
      .LD      (LD),
      .IEN     (IEN),
      .FGO     (FGO),
      .BUSY    (BUSY),
      .TXD     (TXD),
      .IRQ     (IRQ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Expected line level for frame bit slot idx (0 = start).
   function automatic logic expbit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (idx == 9 && PE) return ^d;
      return 1'b1;
   endfunction

   // Loads d, checks the whole frame cycle by cycle, ends just after the edge FGO rises.
   // A stray LD of sd is pulsed at frame cycle stray_at (negative: none).
   task automatic run_frame(input logic [7:0] d, input int stray_at, input logic [7:0] sd);
      logic exp_txd;
      Data_in = d;
      LD      = 1'b1;
      step();
      LD      = 1'b0;
      for (int k = 0; k <= FL; k++) begin
         if (k < FL) begin
            exp_txd = expbit(d, k / CPB);
            checks++;
            if (TXD !== exp_txd || FGO !== 1'b0 || BUSY !== 1'b1) begin
               errors++;
               $display("FAIL frame d=%h cycle %0d: TXD=%b FGO=%b BUSY=%b, required TXD=%b FGO=0 BUSY=1",
                        d, k, TXD, FGO, BUSY, exp_txd);
            end
         end else begin
            checks++;
            if (TXD !== 1'b1 || FGO !== 1'b1 || BUSY !== 1'b0) begin
               errors++;
               $display("FAIL frame_end d=%h: TXD=%b FGO=%b BUSY=%b, required 1 1 0", d, TXD, FGO, BUSY);
            end
         end
         if (k >= 1) begin
            checks++;
            if (IRQ !== 1'b0) begin
               errors++;
               $display("FAIL irq_in_frame d=%h cycle %0d: IRQ=%b, required 0", d, k, IRQ);
            end
         end
         if (k == stray_at) begin
            LD      = 1'b1;
            Data_in = sd;
         end else if (k == stray_at + 1) begin
            LD      = 1'b0;
            Data_in = d;
         end
         if (k < FL) step();
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      LD = 1'b0; IEN = 1'b0; Data_in = 8'h00;
      step();
      step();
      RST_N = 1'b1;
      checks++;
      if (FGO !== 1'b1 || TXD !== 1'b1 || BUSY !== 1'b0 || IRQ !== 1'b0) begin
         errors++;
         $display("FAIL reset: FGO=%b TXD=%b BUSY=%b IRQ=%b, required 1 1 0 0", FGO, TXD, BUSY, IRQ);
      end
      for (int i = 0; i < 100; i++) begin
         step();
         checks++;
         if (FGO !== 1'b1 || TXD !== 1'b1 || BUSY !== 1'b0 || IRQ !== 1'b0) begin
            errors++;
            $display("FAIL idle cycle %0d: FGO=%b TXD=%b BUSY=%b IRQ=%b, required 1 1 0 0", i, FGO, TXD, BUSY, IRQ);
         end
      end
   endtask

   task automatic test_single_byte();
      run_frame(8'hA5, -1, 8'h00);
      step();
   endtask

   task automatic test_ld_while_busy();
      run_frame(8'h3C, 20, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (FGO !== 1'b1 || TXD !== 1'b1) begin
            errors++;
            $display("FAIL busy_drop_idle %0d: FGO=%b TXD=%b, required 1 1", i, FGO, TXD);
         end
      end
   endtask

   task automatic test_back_to_back();
      // Stray LD on the final STOP cycle must be ignored.
      run_frame(8'hC3, FL - 1, 8'hFF);
      run_frame(8'h01, -1, 8'h00);
      step();
   endtask

   task automatic test_reset_mid_frame();
      Data_in = 8'h00;
      LD      = 1'b1;
      step();
      LD      = 1'b0;
      for (int k = 0; k < 50; k++) step();
      checks++;
      if (TXD !== 1'b0 || BUSY !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: TXD=%b BUSY=%b, required 0 1", TXD, BUSY);
      end
      RST_N   = 1'b0;
      LD      = 1'b1;
      Data_in = 8'hFF;
      step();
      checks++;
      if (TXD !== 1'b1 || FGO !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: TXD=%b FGO=%b BUSY=%b, required 1 1 0", TXD, FGO, BUSY);
      end
      step();
      checks++;
      if (TXD !== 1'b1 || FGO !== 1'b1 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL reset_ld_ignored: TXD=%b FGO=%b BUSY=%b, required 1 1 0", TXD, FGO, BUSY);
      end
      RST_N = 1'b1;
      LD    = 1'b0;
      step();
      run_frame(8'h55, -1, 8'h00);
      step();
   endtask

   task automatic test_irq_parity();
      IEN = 1'b1;
      step();
      checks++;
      if (IRQ !== 1'b1) begin
         errors++;
         $display("FAIL irq_idle: IRQ=%b, required 1", IRQ);
      end
      run_frame(8'h07, -1, 8'h00);
      step();
      checks++;
      if (IRQ !== 1'b1) begin
         errors++;
         $display("FAIL irq_after_fgo: IRQ=%b, required 1", IRQ);
      end
      run_frame(8'h03, -1, 8'h00);
      step();
      IEN = 1'b0;
      step();
      checks++;
      if (IRQ !== 1'b0) begin
         errors++;
         $display("FAIL irq_ien_low: IRQ=%b, required 0", IRQ);
      end
   endtask

   initial begin
      RST_N = 1'b0; LD = 1'b0; IEN = 1'b0; Data_in = 8'h00;
      test_reset();
      test_single_byte();
      test_ld_while_busy();
      test_back_to_back();
      test_reset_mid_frame();
      test_irq_parity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
